// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings
// and the byte-enable pattern for a given access size and byte offset.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // size is funct3[1:0]; the offset k is already known to be aligned for the size
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] k);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << k;
      2'b01:   be = 4'b0011 << k;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-addressed data-memory port: request/grant for the access, rvalid for read data.
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            k,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = rdata[{k, 3'b000} +: 8];
    half_s = rdata[{k[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = DATA_WIDTH'(byte_s);
      F3_H:    load_data = DATA_WIDTH'(half_s);
      F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_s};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: latches a load/store from EX, runs the data-memory handshake and
// returns aligned load data with a one-cycle wb_valid, stalling upstream meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  lsu_err,
  lsu_if.master                 dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            k_q;
  logic [DM_ADDRESS-1:0] waddr_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] sdata_q;
  logic                  store_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic [DATA_WIDTH-1:0] ext_data;
  logic                  accept, f3_legal, misaligned, illegal, timed_out;
  logic                  addr_hi_unused;

  assign addr_hi_unused = ^alu_result[DATA_WIDTH-1:DM_ADDRESS+2];

  assign accept    = ex_valid & (mem_read | mem_write);
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // Stores only have signed-agnostic sizes, so BU/HU are legal for loads alone
  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~mem_write;
      default:          f3_legal = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                 ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
    illegal    = (mem_read & mem_write) | ~f3_legal | misaligned;
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .rdata     (dmem.mem_rdata),
    .k         (k_q),
    .funct3    (f3_q),
    .load_data (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = illegal ? DONE : REQ;
      REQ:  if (dmem.mem_gnt) state_d = store_q ? DONE : WAIT;
      WAIT: if (dmem.mem_rvalid || timed_out) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall          = ((state_q == IDLE) & accept) | (state_q == REQ) | (state_q == WAIT);
    wb_valid       = (state_q == DONE);
    lsu_err        = (state_q == DONE) & err_q;
    load_data      = load_data_q;
    dmem.mem_req   = (state_q == REQ);
    dmem.mem_we    = (state_q == REQ) & store_q;
    dmem.mem_be    = (state_q == REQ) ? be_for(f3_q[1:0], k_q) : 4'b0000;
    dmem.mem_addr  = waddr_q;
    case (f3_q[1:0])
      2'b00:   dmem.mem_wdata = {4{sdata_q[7:0]}};
      2'b01:   dmem.mem_wdata = {2{sdata_q[15:0]}};
      default: dmem.mem_wdata = sdata_q;
    endcase
  end

  // load_data only changes on the transition into DONE and holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      waddr_q     <= '0;
      f3_q        <= '0;
      sdata_q     <= '0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          k_q     <= alu_result[1:0];
          waddr_q <= alu_result[DM_ADDRESS+1:2];
          f3_q    <= funct3;
          sdata_q <= store_data;
          store_q <= mem_write;
          err_q   <= illegal;
          if (illegal) load_data_q <= '0;
        end
        REQ: if (dmem.mem_gnt && store_q) load_data_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem.mem_rvalid) begin
            load_data_q <= ext_data;
          end else if (timed_out) begin
            load_data_q <= '0;
            err_q       <= 1'b1;
          end
        end
        DONE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives EX requests and a scripted memory,
// compares handshake, lanes, load data, errors and latency with hand-computed values.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        stall, wb_valid, lsu_err;
  logic [31:0] load_data;

  lsu_if #(.DATA_WIDTH(32), .DM_ADDRESS(9)) dmem ();

  load_store_unit #(.DATA_WIDTH(32), .DM_ADDRESS(9), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .load_data  (load_data),
    .lsu_err    (lsu_err),
    .dmem       (dmem)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // results of the most recent run_access
  int          r_lat;
  logic [31:0] r_ld;
  logic        r_err, r_req_seen, r_stable, r_stall_ok, r_done_stall, r_extra_wb, r_done;
  logic [8:0]  r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic        r_we;

  // Issues one access in the current cycle and plays the memory side: gnt on the
  // (gnt_dly)th REQ cycle, rvalid on the (rv_dly)th WAIT cycle (-1 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int   reqn, waitn;
    logic waiting, gnt_now;
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_result = addr; store_data = sdata;
    r_req_seen = 0; r_stable = 1; r_stall_ok = 1; r_done = 0; r_lat = -1;
    r_ld = 32'hx; r_err = 1'bx; r_done_stall = 1'bx;
    reqn = 0; waitn = 0; waiting = 0;
    for (int cyc = 0; cyc < 600 && !r_done; cyc++) begin
      gnt_now = 1'b0;
      if (dmem.mem_req) begin
        if (!r_req_seen) begin
          r_req_seen = 1; r_addr = dmem.mem_addr; r_be = dmem.mem_be;
          r_wd = dmem.mem_wdata; r_we = dmem.mem_we;
        end else if (dmem.mem_addr !== r_addr || dmem.mem_be !== r_be ||
                     dmem.mem_wdata !== r_wd || dmem.mem_we !== r_we) begin
          r_stable = 0;
        end
        gnt_now = (reqn == gnt_dly);
        reqn++;
        dmem.mem_gnt = gnt_now;
      end
      if (waiting) begin
        waitn++;
        dmem.mem_rvalid = (waitn == rv_dly);
        dmem.mem_rdata  = dmem.mem_rvalid ? rdata : ~rdata;
      end
      @(negedge clk);
      if (wb_valid) begin
        r_done = 1; r_lat = cyc; r_ld = load_data; r_err = lsu_err; r_done_stall = stall;
      end else if (!stall) begin
        r_stall_ok = 0;
      end
      if (gnt_now && rd && !wr) waiting = 1;
      tick();
      ex_valid = 1'b0; alu_result = ~addr; store_data = ~sdata;
      dmem.mem_gnt = 1'b0; dmem.mem_rvalid = 1'b0;
    end
    check("completed", 32'(r_done), 32'd1);
    @(negedge clk);
    r_extra_wb = wb_valid;
    tick();
  endtask

  initial begin
    reset = 1'b1; ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_result = 0; store_data = 0;
    dmem.mem_gnt = 0; dmem.mem_rvalid = 0; dmem.mem_rdata = 0;
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_wb", 32'(wb_valid), 0);
    check("rst_req", 32'(dmem.mem_req), 0);
    check("rst_ld", load_data, 0);
    check("rst_err", 32'(lsu_err), 0);
    tick();
    reset = 1'b0;
    tick();

    // SW, grant in the first REQ cycle
    run_access(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 0, -1, 0);
    check("sw_addr", 32'(r_addr), 32'd4);
    check("sw_be", 32'(r_be), 32'hF);
    check("sw_wdata", r_wd, 32'hDEADBEEF);
    check("sw_we", 32'(r_we), 1);
    check("sw_lat", 32'(r_lat), 2);
    check("sw_err", 32'(r_err), 0);
    check("sw_ld", r_ld, 0);
    check("sw_done_stall", 32'(r_done_stall), 0);
    check("sw_once", 32'(r_extra_wb), 0);

    // LB / LBU from byte 3 of 0x80FF7F01, rvalid on the 3rd WAIT cycle
    run_access(1, 0, F3_B, 32'h13, 0, 0, 3, 32'h80FF7F01);
    check("lb_ld", r_ld, 32'hFFFFFF80);
    check("lb_lat", 32'(r_lat), 5);
    check("lb_stall", 32'(r_stall_ok), 1);
    check("lb_addr", 32'(r_addr), 32'd4);
    check("lb_we", 32'(r_we), 0);
    check("lb_err", 32'(r_err), 0);
    run_access(1, 0, F3_BU, 32'h13, 0, 0, 3, 32'h80FF7F01);
    check("lbu_ld", r_ld, 32'h00000080);

    // Reset during WAIT, then a stray rvalid
    ex_valid = 1; mem_read = 1; mem_write = 0; funct3 = F3_W; alu_result = 32'h24;
    @(negedge clk);
    tick();
    ex_valid = 0; dmem.mem_gnt = 1;
    @(negedge clk);
    check("mr_req", 32'(dmem.mem_req), 1);
    tick();
    dmem.mem_gnt = 0;
    @(negedge clk);
    check("mr_wait_stall", 32'(stall), 1);
    tick();
    reset = 1'b1;
    #1;
    check("mr_stall", 32'(stall), 0);
    check("mr_req0", 32'(dmem.mem_req), 0);
    check("mr_wb", 32'(wb_valid), 0);
    check("mr_ld", load_data, 0);
    check("mr_err", 32'(lsu_err), 0);
    tick();
    reset = 1'b0; dmem.mem_rvalid = 1; dmem.mem_rdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mr_no_wb", 32'(wb_valid), 0);
      check("mr_idle", 32'(dmem.mem_req | stall), 0);
      tick();
      dmem.mem_rvalid = 0;
    end
    run_access(0, 1, F3_W, 32'h20, 32'h000055AA, 0, -1, 0);
    check("mr_sw_lat", 32'(r_lat), 2);
    check("mr_sw_addr", 32'(r_addr), 32'd8);
    check("mr_sw_err", 32'(r_err), 0);

    // SH to upper half; misaligned LH
    run_access(0, 1, F3_H, 32'h6, 32'h00001234, 0, -1, 0);
    check("sh_be", 32'(r_be), 32'hC);
    check("sh_wdata", r_wd, 32'h12341234);
    check("sh_addr", 32'(r_addr), 32'd1);
    run_access(1, 0, F3_H, 32'h5, 0, 0, 1, 32'hFFFFFFFF);
    check("lh_mis_err", 32'(r_err), 1);
    check("lh_mis_req", 32'(r_req_seen), 0);
    check("lh_mis_lat", 32'(r_lat), 1);
    check("lh_mis_ld", r_ld, 0);

    // SB lane, illegal encodings
    run_access(0, 1, F3_B, 32'h11, 32'h000000AB, 0, -1, 0);
    check("sb_be", 32'(r_be), 32'h2);
    check("sb_wdata", r_wd, 32'hABABABAB);
    run_access(0, 1, F3_BU, 32'h0, 32'h1, 0, -1, 0);
    check("sbu_err", 32'(r_err), 1);
    check("sbu_req", 32'(r_req_seen), 0);
    run_access(1, 1, F3_W, 32'h0, 32'h1, 0, 1, 0);
    check("rdwr_err", 32'(r_err), 1);
    run_access(0, 1, F3_W, 32'h2, 32'h1, 0, -1, 0);
    check("sw_mis_err", 32'(r_err), 1);

    // Halfword loads from the upper half
    run_access(1, 0, F3_H, 32'h12, 0, 1, 1, 32'h80FF7F01);
    check("lh_ld", r_ld, 32'hFFFF80FF);
    check("lh_lat", 32'(r_lat), 4);
    run_access(1, 0, F3_HU, 32'h12, 0, 0, 2, 32'h80FF7F01);
    check("lhu_ld", r_ld, 32'h000080FF);

    // LW timeout
    run_access(1, 0, F3_W, 32'h30, 0, 0, -1, 0);
    check("to_err", 32'(r_err), 1);
    check("to_lat", 32'(r_lat), 32'(2 + TIMEOUT));
    check("to_ld", r_ld, 0);
    check("to_once", 32'(r_extra_wb), 0);

    // LW then SW, grant delayed 4 cycles each
    run_access(1, 0, F3_W, 32'h40, 0, 4, 1, 32'h11223344);
    check("b2b_lw_ld", r_ld, 32'h11223344);
    check("b2b_lw_stable", 32'(r_stable), 1);
    check("b2b_lw_lat", 32'(r_lat), 7);
    check("b2b_lw_once", 32'(r_extra_wb), 0);
    run_access(0, 1, F3_W, 32'h44, 32'hCAFEF00D, 4, -1, 0);
    check("b2b_sw_stable", 32'(r_stable), 1);
    check("b2b_sw_addr", 32'(r_addr), 32'h11);
    check("b2b_sw_wdata", r_wd, 32'hCAFEF00D);
    check("b2b_sw_lat", 32'(r_lat), 6);
    check("b2b_sw_once", 32'(r_extra_wb), 0);
    check("b2b_sw_err", 32'(r_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
